// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-main-memory interface.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_WAIT  = 2'd3
  } mem_state_e;

  localparam int unsigned DEF_WORDS_PER_BLOCK = 4;
  localparam int unsigned DEF_READ_LATENCY    = 4;
  localparam int unsigned DEF_WRITE_LATENCY   = 4;
  localparam int unsigned BLK_OFF_W           = $clog2(DEF_WORDS_PER_BLOCK);

endpackage

// File: rtl/main_memory_array.sv
// Backing word array: synchronous write, combinational read, one shared address.
module main_memory_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  // Commit a word at the closing edge of a write-enable cycle; contents survive reset.
  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory responder: block refills and single-word writes with fixed latency.
module main_memory_responder
  import mem_if_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH      = 32,
  parameter  int unsigned ADDR_WIDTH      = 10,
  parameter  int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter  int unsigned READ_LATENCY    = DEF_READ_LATENCY,
  parameter  int unsigned WRITE_LATENCY   = DEF_WRITE_LATENCY,
  localparam int unsigned OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Ready,
  output logic                  RdValid,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic [OFF_W-1:0]      RdWordIdx,
  output logic                  WrDone
);

  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // Read wait is entered one cycle after acceptance and the burst must start at k+READ_LATENCY,
  // so the read counter is preloaded with READ_LATENCY-2 and RD_WAIT is skipped when it is 1.
  localparam logic [CNT_W-1:0]      RD_LOAD  = (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;
  localparam logic [CNT_W-1:0]      WR_LOAD  = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [OFF_W-1:0]      LAST_IDX = OFF_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~ADDR_WIDTH'(WORDS_PER_BLOCK - 1);

  mem_state_e            r_state,   w_state_nxt;
  logic [CNT_W-1:0]      r_cnt,     w_cnt_nxt;
  logic [OFF_W-1:0]      r_idx,     w_idx_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,    w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,   w_wdata_nxt;
  logic [DATA_WIDTH-1:0] r_rd_hold;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic                  w_mem_we;

  // Next-state, counter and handshake decode; Ready/RdValid/WrDone follow the state only.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    Ready       = 1'b0;
    RdValid     = 1'b0;
    WrDone      = 1'b0;
    unique case (r_state)
      IDLE: begin
        Ready = 1'b1;
        if (MemWrite) begin
          w_state_nxt = WR_WAIT;
          w_cnt_nxt   = WR_LOAD;
          w_addr_nxt  = Address;
          w_wdata_nxt = WriteData;
        end else if (MemRead) begin
          w_addr_nxt = Address & BLK_MASK;
          if (READ_LATENCY > 1) begin
            w_state_nxt = RD_WAIT;
            w_cnt_nxt   = RD_LOAD;
          end else begin
            w_state_nxt = RD_BURST;
            w_idx_nxt   = '0;
          end
        end
      end
      RD_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RD_BURST;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RD_BURST: begin
        RdValid = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = IDLE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      WR_WAIT: begin
        if (r_cnt == '0) begin
          WrDone      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counters, latched request and last-beat hold register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_hold <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      if (RdValid) begin
        r_rd_hold <= w_mem_rdata;
      end
    end
  end

  // A reset edge coinciding with WrDone drops the write.
  assign w_mem_we   = WrDone & RST;
  assign w_mem_addr = (r_state == WR_WAIT) ? r_addr : (r_addr + ADDR_WIDTH'(r_idx));
  assign RdData     = RdValid ? w_mem_rdata : r_rd_hold;
  assign RdWordIdx  = r_idx;

  main_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .CLK     (CLK),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder.
module tb_main_memory_responder;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 10;
  localparam int unsigned WPB = 4;
  localparam int unsigned RL  = 4;
  localparam int unsigned WL  = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [DW-1:0] WriteData = '0;
  logic          Ready;
  logic          RdValid;
  logic [DW-1:0] RdData;
  logic [1:0]    RdWordIdx;
  logic          WrDone;

  main_memory_responder #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .WORDS_PER_BLOCK (WPB),
    .READ_LATENCY    (RL),
    .WRITE_LATENCY   (WL)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .Ready     (Ready),
    .RdValid   (RdValid),
    .RdData    (RdData),
    .RdWordIdx (RdWordIdx),
    .WrDone    (WrDone)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t       rd_q[$];
  int          wr_q[$];
  logic [31:0] model [int];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_beats  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mval(input int a);
    return model.exists(a) ? model[a] : 32'h0;
  endfunction

  // Monitor: pops expected beats / write completions as the DUT produces them.
  always @(negedge CLK) begin
    beat_t e;
    int    ec;
    if (RdValid) begin
      n_beats++;
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 64'(1), 64'(0));
      end else begin
        e = rd_q.pop_front();
        check("rd_cycle", 64'(cyc), 64'(e.cyc));
        check("rd_idx", 64'(RdWordIdx), 64'(e.idx));
        check("rd_data", 64'(RdData), 64'(e.data));
      end
    end
    if (WrDone) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", 64'(1), 64'(0));
      end else begin
        ec = wr_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  // Issue one request once Ready is seen; k is the acceptance cycle.
  task automatic do_req(input bit rd, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input bit commit, output int k);
    int            waited;
    logic [AW-1:0] base;
    waited = 0;
    @(negedge CLK);
    while (!Ready && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    check("req_ready", 64'(Ready), 64'(1));
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = data;
    k = cyc;
    if (wr) begin
      wr_q.push_back(k + int'(WL));
      if (commit) model[int'(addr)] = data;
    end else if (rd) begin
      base = addr & ~10'(WPB - 1);
      for (int i = 0; i < int'(WPB); i++)
        rd_q.push_back('{k + int'(RL) + i, 2'(i), mval(int'(base) + i)});
    end
    @(negedge CLK);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int waited;
    waited = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    check(tag, 64'(rd_q.size() + wr_q.size()), 64'(0));
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, b0;
    logic [31:0] a [4];
    a[0] = 32'hA0A0_0000; a[1] = 32'hA1A1_1111; a[2] = 32'hA2A2_2222; a[3] = 32'hA3A3_3333;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_ready", 64'(Ready), 64'(1));
    check("rst_rdvalid", 64'(RdValid), 64'(0));
    check("rst_wrdone", 64'(WrDone), 64'(0));
    check("rst_rddata", 64'(RdData), 64'(0));
    check("rst_rdidx", 64'(RdWordIdx), 64'(0));
    RST = 1'b1;

    // Refill of block 8 requested at an unaligned address
    for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 10'(8 + i), a[i], 1'b1, k);
    do_req(1'b1, 1'b0, 10'd10, '0, 1'b1, k);
    wait_idle("refill_drain");
    check("hold_data", 64'(RdData), 64'(a[3]));
    check("hold_idx", 64'(RdWordIdx), 64'(3));

    // Write then read, back-to-back acceptance
    do_req(1'b0, 1'b1, 10'd9, 32'hDEADBEEF, 1'b1, k);
    do_req(1'b1, 1'b0, 10'd8, '0, 1'b1, k2);
    check("wr_rd_gap", 64'(k2 - k), 64'(5));
    wait_idle("wrrd_drain");

    // Simultaneous read+write: write wins
    for (int i = 5; i < 8; i++) do_req(1'b0, 1'b1, 10'(i), 32'h4444_0000 + 32'(i), 1'b1, k);
    do_req(1'b1, 1'b1, 10'd4, 32'h4444_0004, 1'b1, k);
    wait_idle("rdwr_drain");
    do_req(1'b1, 1'b0, 10'd6, '0, 1'b1, k);
    wait_idle("rdwr_readback");

    // Requests while busy are ignored
    b0 = n_beats;
    do_req(1'b1, 1'b0, 10'd8, '0, 1'b1, k);
    for (int c = 1; c <= 7; c++) begin
      check("busy_ready", 64'(Ready), 64'(0));
      MemRead   = 1'b1;
      MemWrite  = c[0];
      Address   = 10'($urandom);
      WriteData = $urandom;
      @(negedge CLK);
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    check("ready_back", 64'(Ready), 64'(1));
    wait_idle("busy_drain");
    check("busy_beats", 64'(n_beats - b0), 64'(4));

    // Reset during write wait drops the write
    do_req(1'b0, 1'b1, 10'd5, 32'h5555_5555, 1'b0, k);
    @(negedge CLK);
    RST = 1'b0;
    wr_q.delete();
    @(negedge CLK);
    check("wrst_ready", 64'(Ready), 64'(1));
    check("wrst_wrdone", 64'(WrDone), 64'(0));
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    do_req(1'b1, 1'b0, 10'd5, '0, 1'b1, k);
    wait_idle("wrst_readback");

    // Top-of-array block, no wrap
    for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 10'(1020 + i), 32'hF00D_0000 + 32'(i), 1'b1, k);
    do_req(1'b1, 1'b0, 10'd1023, '0, 1'b1, k);
    wait_idle("top_drain");

    // Reset mid-burst aborts remaining beats
    b0 = n_beats;
    do_req(1'b1, 1'b0, 10'd8, '0, 1'b1, k);
    while (cyc < k + 5) @(negedge CLK);
    #1;
    RST = 1'b0;
    rd_q.delete();
    @(negedge CLK);
    check("brst_ready", 64'(Ready), 64'(1));
    check("brst_rdvalid", 64'(RdValid), 64'(0));
    check("brst_wrdone", 64'(WrDone), 64'(0));
    check("brst_rddata", 64'(RdData), 64'(0));
    @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    check("brst_beats", 64'(n_beats - b0), 64'(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
